// File: rtl/dtree_seq_if.sv
// Handshake bundle between the byte-stream source / result sink and the
// decision-tree feature sequencer.
//   in_data/in_valid/in_ready    : feature byte stream into the sequencer
//   res_valid/res_ready/res_class: classification result out of the sequencer
//   res_tag                      : sample index, only when DTREE_SEQ_SAMPLE_TAG_EN is defined
// modport master: environment side (byte source + result sink)
// modport slave : sequencer side
interface dtree_seq_if #(
    parameter int unsigned FEAT_W = 8,
    parameter int unsigned CLS_W  = 1
);
    logic [FEAT_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              res_valid;
    logic              res_ready;
    logic [CLS_W-1:0]  res_class;
`ifdef DTREE_SEQ_SAMPLE_TAG_EN
    logic [15:0]       res_tag;

    modport master (output in_data, in_valid, res_ready,
                    input  in_ready, res_valid, res_class, res_tag);
    modport slave  (input  in_data, in_valid, res_ready,
                    output in_ready, res_valid, res_class, res_tag);
`else
    modport master (output in_data, in_valid, res_ready,
                    input  in_ready, res_valid, res_class);
    modport slave  (input  in_data, in_valid, res_ready,
                    output in_ready, res_valid, res_class);
`endif
endinterface

// File: rtl/dtree_feature_sequencer.sv
// Front-end for the combinational decision-tree classifier: assembles one
// sample from a byte stream, holds X0..X4 stable for SETTLE_CYC clocks,
// then captures tree_out as the class and offers it on a valid/ready port.
// The next sample is collected while the current one is evaluated or held.
// Ports:
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   bus       : dtree_seq_if.slave (byte input + result output handshakes)
//   X0..X4    : registered features driven to the tree inputs
//   tree_out  : class output of the tree (combinational from X0..X4)
// Option macro DTREE_SEQ_SAMPLE_TAG_EN: adds bus.res_tag, a 16-bit sample
// index latched at commit (wraps 0xFFFF -> 0x0000).
module dtree_feature_sequencer #(
    parameter int unsigned N_FEAT     = 5,
    parameter int unsigned FEAT_W     = 8,
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned CLS_W      = 1
) (
    input  logic              clk,
    input  logic              rst,
    dtree_seq_if.slave        bus,
    output logic [FEAT_W-1:0] X0,
    output logic [FEAT_W-1:0] X1,
    output logic [FEAT_W-1:0] X2,
    output logic [FEAT_W-1:0] X3,
    output logic [FEAT_W-1:0] X4,
    input  logic [CLS_W-1:0]  tree_out
);
    localparam int unsigned CNT_W = $clog2(N_FEAT + 1);
    localparam int unsigned SET_W = 4;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RESULT} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   byte_cnt;
    logic [SET_W-1:0]   settle_cnt;
    logic [FEAT_W-1:0]  feat_buf [N_FEAT];
    logic [FEAT_W-1:0]  x_q      [N_FEAT];
    logic               res_valid_q;
    logic [CLS_W-1:0]   res_class_q;
    logic               buf_full;
    logic               accept;
    logic               commit;
    logic               capture;
    logic               release_res;

    assign buf_full     = (byte_cnt == CNT_W'(N_FEAT));
    // in_ready is held low by reset itself, not only by the cleared counter
    assign bus.in_ready = !rst && (byte_cnt < CNT_W'(N_FEAT));
    assign accept       = bus.in_valid && bus.in_ready;

    // Next-state and per-cycle action strobes
    always_comb begin
        state_nxt   = state;
        commit      = 1'b0;
        capture     = 1'b0;
        release_res = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (buf_full) begin
                    commit    = 1'b1;
                    state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = S_RESULT;
                end
            end
            S_RESULT: begin
                if (bus.res_ready) begin
                    release_res = 1'b1;
                    // a waiting full buffer commits on the same edge, skipping IDLE
                    if (buf_full) begin
                        commit    = 1'b1;
                        state_nxt = S_SETTLE;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register and datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            byte_cnt    <= '0;
            settle_cnt  <= '0;
            res_valid_q <= 1'b0;
            res_class_q <= '0;
            feat_buf    <= '{default: '0};
            x_q         <= '{default: '0};
        end else begin
            state <= state_nxt;

            // accept and commit are mutually exclusive: commit needs buf_full
            if (accept) begin
                feat_buf[byte_cnt] <= bus.in_data;
                byte_cnt           <= byte_cnt + CNT_W'(1);
            end

            if (commit) begin
                x_q        <= feat_buf;
                byte_cnt   <= '0;
                settle_cnt <= SET_W'(SETTLE_CYC - 1);
            end else if (state == S_SETTLE && settle_cnt != '0) begin
                settle_cnt <= settle_cnt - SET_W'(1);
            end

            if (capture) begin
                res_class_q <= tree_out;
                res_valid_q <= 1'b1;
            end else if (release_res) begin
                res_valid_q <= 1'b0;
            end
        end
    end

`ifdef DTREE_SEQ_SAMPLE_TAG_EN
    logic [15:0] sample_cnt;
    logic [15:0] tag_q;

    // Sample index: value before the increment is the tag of this commit
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_cnt <= '0;
            tag_q      <= '0;
        end else if (commit) begin
            tag_q      <= sample_cnt;
            sample_cnt <= sample_cnt + 16'd1;
        end
    end

    assign bus.res_tag = tag_q;
`endif

    assign bus.res_valid = res_valid_q;
    assign bus.res_class = res_class_q;
    assign X0 = x_q[0];
    assign X1 = x_q[1];
    assign X2 = x_q[2];
    assign X3 = x_q[3];
    assign X4 = x_q[4];
endmodule

// File: tb/tb_dtree_feature_sequencer.sv
// Directed bench for dtree_feature_sequencer with a small behavioural tree:
// class = (X0 >= 0x10) ? (X3 > 0x18) : X4[0].
// Inputs change and outputs are sampled on the falling clock edge.
module tb_dtree_feature_sequencer;
    localparam int unsigned SETTLE_CYC = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] x0, x1, x2, x3, x4;
    logic       tree_out;
    int         n_cmp = 0;
    int         n_err = 0;
`ifdef DTREE_SEQ_SAMPLE_TAG_EN
    int         tag_next = 0;
`endif

    dtree_seq_if #(.FEAT_W(8), .CLS_W(1)) bus ();

    dtree_feature_sequencer #(
        .N_FEAT(5), .FEAT_W(8), .SETTLE_CYC(SETTLE_CYC), .CLS_W(1)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .X0(x0), .X1(x1), .X2(x2), .X3(x3), .X4(x4),
        .tree_out(tree_out)
    );

    always #5 clk = ~clk;

    always_comb tree_out = (x0 >= 8'h10) ? (x3 > 8'h18) : x4[0];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [39:0] s, input int i);
        return s[39-8*i -: 8];
    endfunction

    // Present one byte and return at the falling edge after it is accepted
    task automatic push(input logic [7:0] b);
        int n = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n == 64) check("push_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic send_sample(input logic [39:0] s, input int gap);
        for (int i = 0; i < 5; i++) begin
            push(byte_of(s, i));
            if (gap > 0 && i < 4) begin
                bus.in_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    // Called at the falling edge right after the commit edge
    task automatic check_commit(input logic [39:0] s, input logic cls, input string tag);
        int cyc = 0;
        check({tag, "_x0"}, x0, byte_of(s, 0));
        check({tag, "_x1"}, x1, byte_of(s, 1));
        check({tag, "_x2"}, x2, byte_of(s, 2));
        check({tag, "_x3"}, x3, byte_of(s, 3));
        check({tag, "_x4"}, x4, byte_of(s, 4));
        check({tag, "_valid_low"}, bus.res_valid, 1'b0);
        while (!bus.res_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, cyc, SETTLE_CYC);
        check({tag, "_class"}, bus.res_class, cls);
`ifdef DTREE_SEQ_SAMPLE_TAG_EN
        check({tag, "_tag"}, bus.res_tag, tag_next);
        tag_next++;
`endif
    endtask

    task automatic consume(input string tag);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check({tag, "_consumed"}, bus.res_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_res_valid", bus.res_valid, 1'b0);
        check("rst_x0", x0, 8'h00);
        check("rst_class", bus.res_class, 1'b0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", bus.in_ready, 1'b1);

        // Continuous in_valid
        send_sample(40'h14_00_0A_20_05, 0);
        check("s1_full_stall", bus.in_ready, 1'b0);
        check("s1_x0_before_commit", x0, 8'h00);
        @(negedge clk);
        check("s1_ready_after_commit", bus.in_ready, 1'b1);
        check_commit(40'h14_00_0A_20_05, 1'b1, "s1");
        consume("s1");

        // One byte every 3 cycles
        send_sample(40'h03_40_11_7F_23, 2);
        @(negedge clk);
        check_commit(40'h03_40_11_7F_23, 1'b1, "s2");
        consume("s2");

        // Result held while the next sample fills the buffer
        send_sample(40'h20_01_02_10_FF, 0);
        @(negedge clk);
        check_commit(40'h20_01_02_10_FF, 1'b0, "s3");
        send_sample(40'h0F_AA_BB_CC_02, 0);
        check("hold_stall", bus.in_ready, 1'b0);
        repeat (3) @(negedge clk);
        check("hold_valid", bus.res_valid, 1'b1);
        check("hold_x0", x0, 8'h20);
        check("hold_x4", x4, 8'hFF);
        check("hold_class", bus.res_class, 1'b0);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check_commit(40'h0F_AA_BB_CC_02, 1'b0, "s4");

        // buf_full and res_ready in the same RESULT cycle
        send_sample(40'h11_00_00_19_00, 0);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check_commit(40'h11_00_00_19_00, 1'b1, "s5");
        consume("s5");

        // Reset mid-sample
        push(8'hAA);
        push(8'hBB);
        push(8'hCC);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst2_in_ready", bus.in_ready, 1'b0);
        check("rst2_x0", x0, 8'h00);
        check("rst2_class", bus.res_class, 1'b0);
        rst = 1'b0;
        #1;
        check("rst2_ready_after", bus.in_ready, 1'b1);
`ifdef DTREE_SEQ_SAMPLE_TAG_EN
        tag_next = 0;
`endif

        // Reset during SETTLE
        send_sample(40'h01_02_03_04_05, 0);
        @(negedge clk);
        check("s6_committed_x0", x0, 8'h01);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst3_x0", x0, 8'h00);
        check("rst3_x4", x4, 8'h00);
        repeat (4) @(negedge clk);
        check("rst3_no_stale_result", bus.res_valid, 1'b0);
`ifdef DTREE_SEQ_SAMPLE_TAG_EN
        tag_next = 0;
`endif

        // Fresh sample after resets
        send_sample(40'h05_06_07_08_09, 0);
        @(negedge clk);
        check_commit(40'h05_06_07_08_09, 1'b1, "s7");
        consume("s7");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
